// File: rtl/frame_serializer_ctrl_if.sv
// Handshake and serial-output bundle between the word source, the pattern matcher and the frame serializer.
// master drives the control and word inputs; slave is the serializer's own view.
interface frame_serializer_ctrl_if #(
    parameter int WORD_W = 16
);
    logic              enable;
    logic              is_matching;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              frame_start;
    logic              frame_done;
    logic              underrun;
    logic [1:0]        state_o;

    modport master (
        output enable, is_matching, s_data, s_valid,
        input  s_ready, ser_out, ser_valid, frame_start, frame_done, underrun, state_o
    );

    modport slave (
        input  enable, is_matching, s_data, s_valid,
        output s_ready, ser_out, ser_valid, frame_start, frame_done, underrun, state_o
    );
endinterface

// File: rtl/frame_serializer_ctrl.sv
// Qualifies a sync run, then shifts FRAME_WORDS words out MSB-first; first bit one cycle after its handshake.
// s_ready is combinational and only opens in RUN on an empty or last-bit shifter; source gaps mid-frame flag underrun.
module frame_serializer_ctrl #(
    parameter int WORD_W      = 16,
    parameter int SYNC_MIN    = 4,
    parameter int FRAME_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    frame_serializer_ctrl_if.slave        bus
);
    localparam int SW = $clog2(SYNC_MIN + 1);
    localparam int WW = $clog2(FRAME_WORDS + 1);
    localparam int BW = $clog2(WORD_W);

    localparam logic [SW-1:0] SYNC_MAX  = SW'(SYNC_MIN);
    localparam logic [WW-1:0] WORDS_MAX = WW'(FRAME_WORDS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_ARMED = 2'b00,
        ST_SYNC  = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    state_t            state_q,       state_d;
    logic [SW-1:0]     sync_cnt_q,    sync_cnt_d;
    logic [WORD_W-1:0] shift_q,       shift_d;
    logic              loaded_q,      loaded_d;
    logic [BW-1:0]     bit_cnt_q,     bit_cnt_d;
    logic [WW-1:0]     words_acc_q,   words_acc_d;
    logic [WW-1:0]     words_sent_q,  words_sent_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q,  frame_done_d;
    logic              underrun_q,    underrun_d;

    logic last_bit;
    logic s_ready_c;
    logic hs;

    assign last_bit  = loaded_q && (bit_cnt_q == BIT_LAST);
    assign s_ready_c = (state_q == ST_RUN) && (words_acc_q < WORDS_MAX)
                       && (!loaded_q || (bit_cnt_q == BIT_LAST));
    assign hs        = s_ready_c && bus.s_valid;

    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        shift_d       = shift_q;
        loaded_d      = loaded_q;
        bit_cnt_d     = bit_cnt_q;
        words_acc_d   = words_acc_q;
        words_sent_d  = words_sent_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        underrun_d    = underrun_q;

        case (state_q)
            ST_ARMED: begin
                if (bus.enable && bus.is_matching) begin
                    state_d    = ST_SYNC;
                    sync_cnt_d = SW'(1);
                end
            end
            ST_SYNC: begin
                if (bus.is_matching) begin
                    if (sync_cnt_q < SYNC_MAX)
                        sync_cnt_d = sync_cnt_q + SW'(1);
                end else begin
                    sync_cnt_d = '0;
                    if (sync_cnt_q >= SYNC_MAX) begin
                        state_d       = ST_RUN;
                        underrun_d    = 1'b0;
                        frame_start_d = 1'b1;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_RUN: begin
                if (loaded_q) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (last_bit) begin
                        words_sent_d = words_sent_q + WW'(1);
                        loaded_d     = 1'b0;
                        bit_cnt_d    = '0;
                    end
                end
                // A handshake on the last bit reloads in place, so consecutive words never bubble.
                if (hs) begin
                    shift_d     = bus.s_data;
                    loaded_d    = 1'b1;
                    bit_cnt_d   = '0;
                    words_acc_d = words_acc_q + WW'(1);
                end
                if (!loaded_q && (words_acc_q != '0) && (words_acc_q < WORDS_MAX) && !bus.s_valid)
                    underrun_d = 1'b1;
                if (last_bit && (words_sent_q == WORDS_MAX - WW'(1))) begin
                    state_d      = ST_ARMED;
                    frame_done_d = 1'b1;
                    words_acc_d  = '0;
                    words_sent_d = '0;
                    loaded_d     = 1'b0;
                    bit_cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ARMED;
            sync_cnt_q    <= '0;
            shift_q       <= '0;
            loaded_q      <= 1'b0;
            bit_cnt_q     <= '0;
            words_acc_q   <= '0;
            words_sent_q  <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            shift_q       <= shift_d;
            loaded_q      <= loaded_d;
            bit_cnt_q     <= bit_cnt_d;
            words_acc_q   <= words_acc_d;
            words_sent_q  <= words_sent_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            underrun_q    <= underrun_d;
        end
    end

    assign bus.s_ready     = s_ready_c;
    assign bus.ser_out     = shift_q[WORD_W-1];
    assign bus.ser_valid   = loaded_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.underrun    = underrun_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_frame_serializer_ctrl.sv
// Directed bench for frame_serializer_ctrl: sync qualification, continuous frames, underrun, late first word, abort, enable.
module tb_frame_serializer_ctrl;
    localparam int WORD_W      = 16;
    localparam int SYNC_MIN    = 4;
    localparam int FRAME_WORDS = 8;
    localparam int FRAME_BITS  = WORD_W * FRAME_WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    frame_serializer_ctrl_if #(.WORD_W(WORD_W)) bus();

    frame_serializer_ctrl #(
        .WORD_W(WORD_W), .SYNC_MIN(SYNC_MIN), .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [15:0] word_of(input int n);
        logic [15:0] base;
        base = 16'hA5C3;
        return base + n[15:0];
    endfunction

    // Drives is_matching high for n_match cycles, drops it, and samples the cycle after.
    task automatic start_frame(input int n_match, output logic fs, output logic [1:0] st);
        @(negedge clk);
        bus.enable      = 1'b1;
        bus.is_matching = 1'b1;
        bus.s_valid     = 1'b0;
        repeat (n_match) @(negedge clk);
        bus.is_matching = 1'b0;
        @(negedge clk);
        #1;
        fs = bus.frame_start;
        st = bus.state_o;
    endtask

    // Feeds words word_of(0..) from the frame_start cycle and records what the serial side shows.
    task automatic run_frame(input int late, input int gap_word, input int gap_len, input int abort_word,
                             output int nvalid, output int first_v, output int last_v, output int done_cyc,
                             output int bit_err, output int ur_first, output int ur_at_done,
                             output int gap_edge, output int start_cyc, output int fs_cnt, output int timeout);
        int          rc, hs_idx, gap_start, abort_at, nxt;
        logic        hs;
        logic [15:0] w;
        nvalid = 0; first_v = -1; last_v = -1; done_cyc = -1; bit_err = 0;
        ur_first = -1; ur_at_done = -1; gap_edge = -1; fs_cnt = 0; timeout = 1;
        rc = 0; hs_idx = 0; gap_start = -1; abort_at = -1; start_cyc = cycle;
        while (rc < 400) begin
            bus.s_valid = !((rc < late) || (gap_start >= 0 && cycle >= gap_start && cycle < gap_start + gap_len));
            bus.s_data  = word_of(hs_idx);
            #1;
            if (bus.frame_start === 1'b1) fs_cnt++;
            if (bus.ser_valid === 1'b1) begin
                w = word_of(nvalid / WORD_W);
                if (nvalid >= FRAME_BITS || bus.ser_out !== w[WORD_W-1 - (nvalid % WORD_W)]) bit_err++;
                if (first_v < 0) first_v = cycle;
                last_v = cycle;
                nvalid++;
            end
            if (bus.underrun === 1'b1 && ur_first < 0) ur_first = cycle;
            if (bus.frame_done === 1'b1) begin
                done_cyc   = cycle;
                ur_at_done = (bus.underrun === 1'b1) ? 1 : 0;
                timeout    = 0;
                break;
            end
            hs  = bus.s_valid && bus.s_ready;
            nxt = cycle + 1;
            @(negedge clk);
            rc++;
            if (hs) begin
                if (hs_idx == gap_word) begin
                    gap_edge  = nxt;
                    gap_start = nxt + WORD_W - 1;
                end
                if (hs_idx == abort_word) abort_at = nxt + 5;
                hs_idx++;
            end
            if (abort_at >= 0 && cycle == abort_at) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.enable = 1'b1; bus.is_matching = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_cmp++; if ({bus.ser_out, bus.ser_valid, bus.frame_start, bus.frame_done, bus.underrun, bus.s_ready} !== 6'b0) begin
                n_bad++; $display("FAIL reset_outputs: got %b required 000000", {bus.ser_out, bus.ser_valid, bus.frame_start, bus.frame_done, bus.underrun, bus.s_ready}); end
            n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b required 00", bus.state_o); end
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (bus.state_o !== 2'b01) begin n_bad++; $display("FAIL reset_release_sync: got %b required 01", bus.state_o); end
        bus.is_matching = 1'b0; bus.s_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL short_run_rearm: got %b required 00", bus.state_o); end
    endtask

    task automatic test_sync_qual();
        logic fs; logic [1:0] st;
        start_frame(3, fs, st);
        n_cmp++; if (fs !== 1'b0) begin n_bad++; $display("FAIL sync3_no_start: got %b required 0", fs); end
        n_cmp++; if (st !== 2'b00) begin n_bad++; $display("FAIL sync3_state: got %b required 00", st); end
    endtask

    task automatic test_continuous();
        logic fs; logic [1:0] st;
        int nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to;
        start_frame(4, fs, st);
        n_cmp++; if (fs !== 1'b1) begin n_bad++; $display("FAIL sync4_start: got %b required 1", fs); end
        n_cmp++; if (st !== 2'b10) begin n_bad++; $display("FAIL sync4_state: got %b required 10", st); end
        bus.enable = 1'b0;
        run_frame(0, -1, 0, -1, nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to);
        n_cmp++; if (to !== 0) begin n_bad++; $display("FAIL cont_timeout: got %0d required 0", to); end
        n_cmp++; if (nv !== FRAME_BITS) begin n_bad++; $display("FAIL cont_bits: got %0d required %0d", nv, FRAME_BITS); end
        n_cmp++; if (lv - fv + 1 !== FRAME_BITS) begin n_bad++; $display("FAIL cont_span: got %0d required %0d", lv - fv + 1, FRAME_BITS); end
        n_cmp++; if (fv - sc !== 1) begin n_bad++; $display("FAIL cont_first_latency: got %0d required 1", fv - sc); end
        n_cmp++; if (be !== 0) begin n_bad++; $display("FAIL cont_bit_errors: got %0d required 0", be); end
        n_cmp++; if (dc !== lv + 1) begin n_bad++; $display("FAIL cont_done_timing: got %0d required %0d", dc, lv + 1); end
        n_cmp++; if (uf !== -1) begin n_bad++; $display("FAIL cont_underrun: got cycle %0d required none", uf); end
        n_cmp++; if (fc !== 1) begin n_bad++; $display("FAIL cont_start_pulse: got %0d required 1", fc); end
        @(negedge clk); #1;
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL cont_done_pulse: got %b required 0", bus.frame_done); end
        n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL cont_rearm: got %b required 00", bus.state_o); end
    endtask

    task automatic test_underrun();
        logic fs; logic [1:0] st;
        int nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to;
        start_frame(5, fs, st);
        n_cmp++; if (fs !== 1'b1) begin n_bad++; $display("FAIL ur_start: got %b required 1", fs); end
        run_frame(0, 1, 3, -1, nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to);
        n_cmp++; if (to !== 0) begin n_bad++; $display("FAIL ur_timeout: got %0d required 0", to); end
        n_cmp++; if (nv !== FRAME_BITS) begin n_bad++; $display("FAIL ur_bits: got %0d required %0d", nv, FRAME_BITS); end
        n_cmp++; if ((lv - fv + 1) - nv !== 3) begin n_bad++; $display("FAIL ur_gap_len: got %0d required 3", (lv - fv + 1) - nv); end
        n_cmp++; if (be !== 0) begin n_bad++; $display("FAIL ur_bit_errors: got %0d required 0", be); end
        n_cmp++; if (uf !== ge + WORD_W + 1) begin n_bad++; $display("FAIL ur_set_cycle: got %0d required %0d", uf, ge + WORD_W + 1); end
        n_cmp++; if (ud !== 1) begin n_bad++; $display("FAIL ur_at_done: got %0d required 1", ud); end
        @(negedge clk); #1;
        n_cmp++; if (bus.underrun !== 1'b1) begin n_bad++; $display("FAIL ur_sticky_armed: got %b required 1", bus.underrun); end
        start_frame(4, fs, st);
        n_cmp++; if (bus.underrun !== 1'b0) begin n_bad++; $display("FAIL ur_clear_at_start: got %b required 0", bus.underrun); end
        run_frame(0, -1, 0, -1, nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to);
        n_cmp++; if (to !== 0 || ud !== 0) begin n_bad++; $display("FAIL ur_next_frame: got timeout %0d underrun %0d required 0 0", to, ud); end
    endtask

    task automatic test_late_first();
        logic fs; logic [1:0] st;
        int nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to;
        @(negedge clk);
        start_frame(4, fs, st);
        run_frame(5, -1, 0, -1, nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to);
        n_cmp++; if (to !== 0) begin n_bad++; $display("FAIL late_timeout: got %0d required 0", to); end
        n_cmp++; if (fv - sc !== 6) begin n_bad++; $display("FAIL late_first_bit: got %0d required 6", fv - sc); end
        n_cmp++; if (uf !== -1) begin n_bad++; $display("FAIL late_underrun: got cycle %0d required none", uf); end
        n_cmp++; if (nv !== FRAME_BITS || lv - fv + 1 !== FRAME_BITS) begin n_bad++; $display("FAIL late_stream: got %0d bits span %0d required %0d", nv, lv - fv + 1, FRAME_BITS); end
        n_cmp++; if (be !== 0) begin n_bad++; $display("FAIL late_bit_errors: got %0d required 0", be); end
    endtask

    task automatic test_abort_enable();
        logic fs; logic [1:0] st;
        int nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to, dones;
        @(negedge clk);
        start_frame(4, fs, st);
        run_frame(0, -1, 0, 3, nv, fv, lv, dc, be, uf, ud, ge, sc, fc, to);
        n_cmp++; if (to !== 0 || dc !== -1) begin n_bad++; $display("FAIL abort_reach: got timeout %0d done %0d required 0 -1", to, dc); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL abort_state: got %b required 00", bus.state_o); end
        n_cmp++; if (bus.ser_valid !== 1'b0) begin n_bad++; $display("FAIL abort_ser_valid: got %b required 0", bus.ser_valid); end
        rst = 1'b0; bus.s_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.frame_done === 1'b1) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d required 0", dones); end
        bus.enable = 1'b0; bus.is_matching = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.state_o !== 2'b00) begin n_bad++; $display("FAIL enable_low_armed: got %b required 00", bus.state_o); end
        end
        bus.enable = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.state_o !== 2'b01) begin n_bad++; $display("FAIL enable_high_sync: got %b required 01", bus.state_o); end
        bus.is_matching = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.enable = 1'b0; bus.is_matching = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        test_reset();
        test_sync_qual();
        test_continuous();
        test_underrun();
        test_late_first();
        test_abort_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_serializer_ctrl.md
Name: frame_serializer_ctrl

Overview:
- Sequences one serializer frame: arms on a sync-pattern run, then serializes exactly FRAME_WORDS parallel words MSB-first, then re-arms.
- Sits between the pattern matcher, which drives is_matching, and the upstream word source, which uses a valid/ready interface.
- Replaces free-running WAITING/ENDING/RUNNING sequencing with bounded frames, a minimum sync length, flow control and underrun detection.

Parameters:
- WORD_W, 16, parallel word width (>=2).
- SYNC_MIN, 4, minimum consecutive is_matching cycles to qualify a sync (>=1).
- FRAME_WORDS, 8, words per frame (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high. Clock is clk.
- enable  in  1  permits arming; sampled only in ARMED.
- is_matching  in  1  sync-pattern match, one sample per cycle.
- s_data  in  WORD_W  upstream word.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  word accepted on the edge where s_valid&&s_ready.
- ser_out  out  1  serial bit, MSB first.
- ser_valid  out  1  ser_out is a valid frame bit this cycle.
- frame_start  out  1  one-cycle pulse, first cycle in RUN.
- frame_done  out  1  one-cycle pulse, cycle after the last bit of the frame.
- underrun  out  1  sticky: the source failed to supply a word mid-frame.
- state_o  out  2  ARMED=00, SYNC=01, RUN=10.

Behaviour:
- Reset: state=ARMED and sync_cnt=0. Shift register, loaded, bit_cnt, words_acc and words_sent are all 0. All outputs are 0, including underrun; state_o=00.
- rst mid-frame aborts immediately. No frame_done is emitted for an aborted frame.
- ARMED: if enable&&is_matching, go to SYNC with sync_cnt=1. Otherwise stay in ARMED.
- SYNC, is_matching=1: stay in SYNC; sync_cnt increments, saturating at SYNC_MIN.
- SYNC, is_matching=0: if sync_cnt>=SYNC_MIN, go to RUN, clear underrun, and pulse frame_start during the first RUN cycle. Otherwise go to ARMED. sync_cnt clears on either exit.
- enable is ignored in SYNC and RUN. A started frame always completes.
- Word acceptance:
  - s_ready = (state==RUN) && words_acc<FRAME_WORDS && (!loaded || bit_cnt==WORD_W-1). This is combinational.
  - On a handshake: shift register <= s_data, loaded<=1, bit_cnt<=0, words_acc++.
- Output timing:
  - ser_out = shift register MSB; ser_valid = loaded.
  - The first bit of an accepted word appears the cycle after its handshake edge.
- While loaded: shift left by 1 and bit_cnt++ each cycle.
  - On bit WORD_W-1: words_sent++.
  - If the same cycle has a handshake, the next word follows with no bubble.
  - Otherwise loaded<=0.
- Back-to-back words give a continuous stream: FRAME_WORDS*WORD_W consecutive ser_valid cycles.
- Underrun:
  - Condition: RUN && !loaded && words_acc>0 && words_acc<FRAME_WORDS && !s_valid.
  - Effect: sets underrun (sticky) and ser_valid=0 that cycle.
  - Waiting for the first word is not an underrun. The gap is allowed; serialization resumes on the next handshake.
- Frame end: when the last bit of word FRAME_WORDS is shifted (words_sent reaches FRAME_WORDS), next state is ARMED. frame_done pulses that next cycle; words_acc, words_sent and loaded clear.
- is_matching is ignored in RUN. Re-arming requires a fresh match run starting in ARMED, earliest the cycle frame_done is high.
- underrun holds until rst or the next frame_start.

Test Plan:
- Reset: assert rst 2 cycles with is_matching=1, s_valid=1 -> all outputs 0, state_o=00; ARMED->SYNC on the first cycle after release.
- Sync qualification: is_matching high 3 cycles then low -> back to ARMED, no frame_start. High 4 cycles then low -> frame_start one cycle, state_o=10.
- Continuous frame: WORD_W=16, FRAME_WORDS=8, s_valid always 1, words 16'hA5C3+n -> 128 consecutive ser_valid cycles, MSB-first bits matching, frame_done one cycle after the last bit, underrun=0.
- Underrun: drop s_valid for 3 cycles after word 2 -> ser_valid low 3 cycles, underrun=1 and stays set through frame_done; cleared at the next frame_start.
- Late first word: s_valid low 5 cycles after frame_start -> no underrun; the frame completes normally.
- Abort and enable: rst mid-word 4 -> state 00 next cycle, no frame_done. enable=0 with is_matching=1 in ARMED -> stays ARMED.
